// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet decoder and cursor tracker: assembles 3-byte packets from the
// receiver byte stream and integrates the signed deltas into a clamped (x, y) position.
module ps2_mouse_tracker #(
    parameter int XW      = 11,
    parameter int YW      = 11,
    parameter int W       = 640,
    parameter int H       = 480,
    parameter int X_INIT  = 320,
    parameter int Y_INIT  = 240,
    parameter int SHIFT   = 0,
    parameter int TIMEOUT = 50000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          left,
    output logic          right,
    output logic          middle,
    output logic          pkt_valid,
    output logic          sync_err,
    output logic [7:0]    err_count
);

    localparam int AW = ((XW > YW) ? XW : YW) + SHIFT + 2;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CW-1:0]        TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic signed [AW-1:0] X_MAX    = AW'(W - 1);
    localparam logic signed [AW-1:0] Y_MAX    = AW'(H - 1);
    localparam logic [XW-1:0]        X_MAX_U  = XW'(W - 1);
    localparam logic [YW-1:0]        Y_MAX_U  = YW'(H - 1);

    typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2, APPLY} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] tmo_reg, tmo_next;

    logic          latch_status, latch_dx, latch_dy;
    logic          frame_err, timeout_hit, err_event;

    // Only the status bits that matter are kept; bit 3 is the framing marker.
    logic [2:0]    btn_reg;
    logic          xs_reg, ys_reg, xo_reg, yo_reg;
    logic [7:0]    dx_reg, dy_reg;

    logic signed [AW-1:0] dx_s, dy_s, x_sum, y_sum;
    logic [XW-1:0]        x_new;
    logic [YW-1:0]        y_new;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= BYTE0;
            tmo_reg   <= '0;
        end else begin
            state_reg <= state_next;
            tmo_reg   <= tmo_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        latch_status = 1'b0;
        latch_dx     = 1'b0;
        latch_dy     = 1'b0;
        frame_err    = 1'b0;
        timeout_hit  = 1'b0;
        case (state_reg)
            BYTE0, APPLY: begin
                // APPLY is a single cycle, but a byte landing in it is a BYTE0 byte.
                state_next = BYTE0;
                if (rx_valid) begin
                    if (rx_data[3]) begin
                        latch_status = 1'b1;
                        state_next   = BYTE1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            BYTE1: begin
                if (rx_valid) begin
                    latch_dx   = 1'b1;
                    state_next = BYTE2;
                end else if (tmo_reg == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = BYTE0;
                end
            end
            BYTE2: begin
                if (rx_valid) begin
                    latch_dy   = 1'b1;
                    state_next = APPLY;
                end else if (tmo_reg == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = BYTE0;
                end
            end
            default: state_next = BYTE0;
        endcase

        tmo_next = '0;
        if ((state_reg == BYTE1 || state_reg == BYTE2) && !rx_valid && !timeout_hit)
            tmo_next = tmo_reg + 1'b1;
    end

    assign err_event = frame_err | timeout_hit;

    // ---------------------------------------------------------------- position arithmetic
    always_comb begin
        dx_s = '0;
        dy_s = '0;
        if (!xo_reg)
            dx_s = $signed({{(AW-9){xs_reg}}, xs_reg, dx_reg}) <<< SHIFT;
        if (!yo_reg)
            dy_s = $signed({{(AW-9){ys_reg}}, ys_reg, dy_reg}) <<< SHIFT;

        // Screen y grows downward while PS/2 +Y is up, hence the subtraction.
        x_sum = $signed({{(AW-XW){1'b0}}, x}) + dx_s;
        y_sum = $signed({{(AW-YW){1'b0}}, y}) - dy_s;

        x_new = x_sum[XW-1:0];
        if (x_sum[AW-1])
            x_new = '0;
        else if (x_sum > X_MAX)
            x_new = X_MAX_U;

        y_new = y_sum[YW-1:0];
        if (y_sum[AW-1])
            y_new = '0;
        else if (y_sum > Y_MAX)
            y_new = Y_MAX_U;
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_reg   <= '0;
            xs_reg    <= 1'b0;
            ys_reg    <= 1'b0;
            xo_reg    <= 1'b0;
            yo_reg    <= 1'b0;
            dx_reg    <= '0;
            dy_reg    <= '0;
            x         <= XW'(X_INIT);
            y         <= YW'(Y_INIT);
            left      <= 1'b0;
            right     <= 1'b0;
            middle    <= 1'b0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            err_count <= '0;
        end else begin
            if (latch_status) begin
                btn_reg <= rx_data[2:0];
                xs_reg  <= rx_data[4];
                ys_reg  <= rx_data[5];
                xo_reg  <= rx_data[6];
                yo_reg  <= rx_data[7];
            end
            if (latch_dx)
                dx_reg <= rx_data;
            if (latch_dy)
                dy_reg <= rx_data;

            pkt_valid <= (state_reg == APPLY);
            if (state_reg == APPLY) begin
                x      <= x_new;
                y      <= y_new;
                left   <= btn_reg[0];
                right  <= btn_reg[1];
                middle <= btn_reg[2];
            end

            sync_err <= err_event;
            if (err_event && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule
